wb_burst_responder: RTL and testbench
=====================================

WB_BURST_RESPONDER -- requirements
Module: wb_burst_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, 2048: RAM depth in 32-bit words; legal byte range is 0 to 4*MEM_WORDS-1.
REQ-002 SHALL have parameter WAIT_CYC, 2: idle cycles between request sampling and the first ack (0-15).
REQ-003 SHALL have parameter INIT_FILE, "": optional hex preload for the RAM; an empty string means no preload.
REQ-004 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; synchronous, active-low.
REQ-006 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone B3 cycle, strobe and write enable.
REQ-007 SHALL have port wb_adr_i  in  32  byte address; bits [1:0] are ignored.
REQ-008 SHALL have ports wb_sel_i  in  4, wb_dat_i  in  32  byte selects and write data.
REQ-009 SHALL have ports wb_cti_i  in  3, wb_bte_i  in  2  cycle type (000 classic, 010 incrementing, 111 end) and burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16).
REQ-010 SHALL have ports wb_ack_o, wb_err_o, wb_rty_o  out  1 each  terminations.
REQ-011 SHALL have port wb_dat_o  out  32  read data.

Function
REQ-012 SHALL implement the states IDLE, WAIT, BURST, CLASSIC, ERR and GAP.
REQ-013 In IDLE, when cyc&stb are sampled high, SHALL latch the word address, we, bte and cti.
REQ-014 From IDLE, SHALL go to ERR if the address is out of range, to WAIT if WAIT_CYC>0, and otherwise to CLASSIC (cti=000) or BURST (cti=010).
REQ-015 In WAIT, SHALL count down from WAIT_CYC; at zero, go to CLASSIC or BURST according to the latched cti.
REQ-016 In CLASSIC, SHALL assert wb_ack_o for exactly 1 cycle and then go to GAP.
REQ-017 In GAP, SHALL hold ack low for 1 cycle and then return to IDLE, so one request never produces two acks.
REQ-018 In BURST, SHALL assert ack in every cycle that cyc&stb are high, advancing the address by one word per ack.
REQ-019 Burst address advance: bte=00 increments the full word address; wrap-k increments the low log2(k) bits modulo k and holds the upper bits.
REQ-020 SHALL end a burst after the ack beat whose sampled cti is 111, going to GAP.
REQ-021 If stb drops mid-burst without cyc dropping, SHALL deassert ack and hold the address; when stb rises again, SHALL resume at the held address.
REQ-022 If cyc drops in any state, SHALL return to IDLE on the next cycle with ack low.
REQ-023 Reads: wb_dat_o SHALL equal RAM[address] in every ack cycle, using the synchronous RAM read address for the next beat. Outside ack cycles wb_dat_o is don't-care and is held at its last value.
REQ-024 Writes: in each ack cycle, SHALL write byte lane n of wb_dat_i into RAM when wb_sel_i[n]=1; lanes with sel=0 SHALL be unchanged.
REQ-025 A linear burst advancing past MEM_WORDS-1 SHALL terminate that beat with err instead of ack, with no write, then go to GAP.
REQ-026 ERR state SHALL assert wb_err_o for 1 cycle, then go to GAP.
REQ-027 ack and err SHALL never be high together; wb_rty_o SHALL be constant 0.
REQ-028 cti=111 on the first request SHALL be treated as classic.
REQ-029 Reserved cti values (001, 011-110) SHALL be treated as classic.

Reset
REQ-030 Reset SHALL drive ack, err, rty and wb_dat_o to 0, the state to IDLE, and the address and counter registers to 0.
REQ-031 RAM contents SHALL be unaffected by reset.
REQ-032 Reset asserted mid-burst SHALL give ack=0 on the cycle after the sampling edge, with no further RAM writes.

Structure
REQ-033 A shared package wb_pkg SHALL hold the CTI_CLASSIC, CTI_INCR and CTI_END constants, the BTE_* constants, and the state encoding.
REQ-034 The block SHALL have a single sub-module, wb_sp_ram: a byte-enable single-port synchronous RAM with a 1-cycle read.

Verification
REQ-035 Wrap8 read, start address 0x14, RAM[i]=i, WAIT_CYC=2, cti=010 for beats 1-7 and 111 on beat 8 -> first ack 3 cycles after request; data 5,6,7,0,1,2,3,4; ack low on the next cycle.
REQ-036 Classic write to 0x40, dat=0xAABBCCDD, sel=0101, prior value 0x11223344 -> exactly one ack; readback gives 0x11BB33DD.
REQ-037 Read of 0x2000 with MEM_WORDS=2048 -> one err cycle, no ack, RAM unchanged.
REQ-038 Linear burst from 0x1FF8 -> acks at 0x1FF8 and 0x1FFC, then err on the third beat.
REQ-039 stb dropped for 3 cycles after beat 2 of a linear burst -> no acks during the gap; beat 3 returns RAM[start+2].
REQ-040 rst_n=0 during beat 4 of a wrap8 write burst -> ack low on the next cycle, only beats 1-3 written, state IDLE.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg -- shared definitions for the Wishbone burst responder.
//   CTI_* : Wishbone B3 cycle type identifiers
//   BTE_* : Wishbone B3 burst type extensions
//   state_t : responder FSM state encoding
//   cti_is_burst() : true only for incrementing-burst cycle type
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_BURST   = 3'd2,
    ST_CLASSIC = 3'd3,
    ST_ERR     = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  // Only an incrementing cycle type opens a burst; end-of-burst on the first
  // request and all reserved codes fall back to a single classic transfer.
  function automatic logic cti_is_burst(input logic [2:0] cti);
    return cti == CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_sp_ram.sv
// wb_sp_ram -- single-port synchronous RAM, 32-bit words, byte enables,
// one-cycle registered read (read-first on a simultaneous write).
//   clk   : clock
//   we    : write strobe
//   be    : byte-lane enables for the write
//   addr  : word address (shared by read and write)
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
module wb_sp_ram #(
    parameter int    WORDS     = 2048,
    parameter int    AW        = 11,
    parameter string INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];
    logic [31:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata_reg <= mem[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/wb_burst_responder.sv
// wb_burst_responder -- Wishbone B3 slave backed by a byte-enable RAM, with
// programmable initial wait states, classic and incrementing bursts
// (linear / wrap4 / wrap8 / wrap16), and error termination for accesses
// outside the RAM.
//   clk, rst_n        : clock, synchronous active-low reset
//   wb_cyc_i/stb_i    : cycle and strobe
//   wb_we_i           : write enable
//   wb_adr_i          : byte address ([1:0] ignored)
//   wb_sel_i/dat_i    : byte selects and write data
//   wb_cti_i/bte_i    : cycle type and burst type
//   wb_ack_o/err_o    : normal and error termination
//   wb_rty_o          : retry, never used (tied low)
//   wb_dat_o          : read data, valid in ack cycles
// MEM_WORDS must be a power of two and at least 32 so that the wrap16 upper
// address field exists.
module wb_burst_responder
  import wb_pkg::*;
#(
  parameter int    MEM_WORDS = 2048,
  parameter int    WAIT_CYC  = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [31:0] wb_dat_o
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [1:0]    bte_q, bte_d;
  logic [2:0]    cti_q, cti_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [31:0]   dat_q, dat_d;

  logic [29:0]   adr_word;
  logic          in_range;
  logic          req;
  logic          beat;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] addr_adv;
  logic          last_word;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          adr_unused;

  assign adr_word   = wb_adr_i[31:2];
  assign adr_unused = ^wb_adr_i[1:0];
  assign in_range   = ({2'b00, adr_word} < 32'(MEM_WORDS));
  assign req        = wb_cyc_i & wb_stb_i;

  // ack_q means "data/termination ready"; a beat only completes while the
  // master is actually strobing, so a paused strobe neither acks nor advances.
  assign beat       = ack_q & req;

  assign last_word  = (addr_q == AW'(MEM_WORDS - 1));

  // Next burst address: wrap modes only touch the low bits of the word address.
  always_comb begin
    addr_inc = addr_q + AW'(1);
    addr_adv = addr_inc;
    case (bte_q)
      BTE_WRAP4:  addr_adv = {addr_q[AW-1:2], addr_inc[1:0]};
      BTE_WRAP8:  addr_adv = {addr_q[AW-1:3], addr_inc[2:0]};
      BTE_WRAP16: addr_adv = {addr_q[AW-1:4], addr_inc[3:0]};
      default:    addr_adv = addr_inc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    bte_d   = bte_q;
    cti_d   = cti_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = adr_word[AW-1:0];
          we_d   = wb_we_i;
          bte_d  = wb_bte_i;
          cti_d  = wb_cti_i;
          if (!in_range) begin
            state_d = ST_ERR;
          end else if (WAIT_CYC > 0) begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYC);
          end else begin
            state_d = cti_is_burst(wb_cti_i) ? ST_BURST : ST_CLASSIC;
          end
        end
      end

      ST_WAIT: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          // Leave as the count reaches zero so exactly WAIT_CYC cycles elapse.
          if (cnt_q == 4'd1) begin
            state_d = cti_is_burst(cti_q) ? ST_BURST : ST_CLASSIC;
          end
        end
      end

      ST_CLASSIC: begin
        if (!wb_cyc_i)  state_d = ST_IDLE;
        else if (beat)  state_d = ST_GAP;
      end

      ST_BURST: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (beat) begin
          if (wb_cti_i == CTI_END) begin
            state_d = ST_GAP;
          end else if (bte_q == BTE_LINEAR && last_word) begin
            // The next linear beat would fall off the end of the RAM.
            state_d = ST_ERR;
          end else begin
            addr_d = addr_adv;
          end
        end
      end

      ST_ERR: begin
        state_d = wb_cyc_i ? ST_GAP : ST_IDLE;
      end

      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d = (state_d == ST_BURST) || (state_d == ST_CLASSIC);
    err_d = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      bte_q   <= 2'b00;
      cti_q   <= 3'b000;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      bte_q   <= bte_d;
      cti_q   <= cti_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // A beat sampled together with reset must not reach the RAM.
  assign ram_we   = beat & we_q & rst_n;

  // Single port: a write beat uses the current address, otherwise the RAM
  // prefetches the address of the next beat so its data is ready on the ack.
  assign ram_addr = ram_we ? addr_q : addr_d;

  wb_sp_ram #(
    .WORDS     (MEM_WORDS),
    .AW        (AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (wb_sel_i),
    .addr  (ram_addr),
    .wdata (wb_dat_i),
    .rdata (ram_rdata)
  );

  // Read data follows the RAM on ack beats and holds its last value otherwise.
  always_comb begin
    dat_d = wb_ack_o ? ram_rdata : dat_q;
  end

  assign wb_ack_o = beat;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = wb_ack_o ? ram_rdata : dat_q;

endmodule

// File: tb/tb_wb_burst_responder.sv
module tb_wb_burst_responder;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;
  logic [31:0] dat_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q [$];
  logic [31:0] wvals [16];

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [2:0]  cti;
    logic [3:0]  sel;
    logic [31:0] data;      // write data, or expected read data
    int          exp_acks;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];
  int   rb_acks;
  logic hit;

  always #5 clk = ~clk;

  wb_burst_responder #(
    .MEM_WORDS (2048),
    .WAIT_CYC  (2),
    .INIT_FILE ("")
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat_i),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_rty_o (rty),
    .wb_dat_o (dat_o)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic vec_t mk(input string n, input logic w, input logic [31:0] a,
                              input logic [2:0] c, input logic [3:0] s, input logic [31:0] d,
                              input int ea, input logic ee);
    vec_t v;
    v.name = n; v.we = w; v.adr = a; v.cti = c; v.sel = s; v.data = d;
    v.exp_acks = ea; v.exp_err = ee;
    return v;
  endfunction

  // One Wishbone transaction; expected read data is taken from exp_q.
  task automatic run_burst(input string name, input logic w, input logic [31:0] a,
                           input logic [2:0] cti1, input logic [1:0] b, input logic [3:0] s,
                           input int nbeats, input int exp_acks, input logic exp_err,
                           input int hold_after, input int hold_len, input int exp_first);
    int   acks      = 0;
    int   it        = 0;
    int   first     = -1;
    int   hold_left = 0;
    int   hold_acks = 0;
    logic got_err   = 1'b0;
    logic both      = 1'b0;
    logic done      = 1'b0;
    while (!done && it < 200) begin
      @(negedge clk);
      cyc = 1'b1; we = w; adr = a; bte = b; sel = s;
      cti = (nbeats == 1) ? cti1 : ((acks == nbeats - 1) ? CTI_END : CTI_INCR);
      dat_i = wvals[acks % 16];
      stb = (hold_left == 0);
      if (hold_left > 0) hold_left--;
      #1;
      if (ack && err) both = 1'b1;
      if (!stb && ack) hold_acks++;
      if (ack) begin
        if (first < 0) first = it;
        if (!w) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb_underflow got=ack want=no_ack", name);
          end else begin
            check({name, "_data"}, dat_o, exp_q.pop_front());
          end
        end
        acks++;
        if (acks == hold_after && hold_len > 0) hold_left = hold_len;
        if (acks == nbeats) done = 1'b1;
      end
      if (err) begin
        got_err = 1'b1;
        done = 1'b1;
      end
      it++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    // One more strobed cycle: the responder must be in its gap, not acking again.
    @(negedge clk);
    stb = 1'b1;
    #1;
    check({name, "_post_ack"}, 32'(ack), 32'd0);
    check({name, "_post_err"}, 32'(err), 32'd0);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check({name, "_acks"}, 32'(acks), 32'(exp_acks));
    check({name, "_err"}, 32'(got_err), 32'(exp_err));
    check({name, "_ack_and_err"}, 32'(both), 32'd0);
    check({name, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    if (exp_first >= 0) check({name, "_first_ack"}, 32'(first), 32'(exp_first));
    if (hold_len > 0) check({name, "_hold_acks"}, 32'(hold_acks), 32'd0);
    $display("txn %s we=%0d adr=%h beats=%0d acks=%0d err=%0d first=%0d",
             name, w, a, nbeats, acks, got_err, first);
  endtask

  initial begin
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0;
    sel = '0; dat_i = '0; cti = '0; bte = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rty", 32'(rty), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload words 0..15 with their own index via a 16-beat linear write.
    for (int k = 0; k < 16; k++) wvals[k] = 32'(k);
    run_burst("preload", 1'b1, 32'h0, CTI_INCR, BTE_LINEAR, 4'hF, 16, 16, 1'b0, -1, 0, -1);

    // Wrap8 read from 0x14, first ack three cycles after the request.
    exp_q = '{32'd5, 32'd6, 32'd7, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    run_burst("wrap8_rd", 1'b0, 32'h14, CTI_INCR, BTE_WRAP8, 4'hF, 8, 8, 1'b0, -1, 0, 3);

    exp_q = '{32'd2, 32'd3, 32'd0, 32'd1};
    run_burst("wrap4_rd", 1'b0, 32'h8, CTI_INCR, BTE_WRAP4, 4'hF, 4, 4, 1'b0, -1, 0, 3);

    for (int k = 0; k < 16; k++) exp_q.push_back(32'((14 + k) % 16));
    run_burst("wrap16_rd", 1'b0, 32'h38, CTI_INCR, BTE_WRAP16, 4'hF, 16, 16, 1'b0, -1, 0, -1);

    // Strobe paused for three cycles after beat 2 of a linear read.
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    run_burst("stb_pause", 1'b0, 32'h0, CTI_INCR, BTE_LINEAR, 4'hF, 5, 5, 1'b0, 2, 3, -1);

    // Classic transfers, table driven.
    vecs[0]  = mk("w40_full",   1'b1, 32'h40,   CTI_CLASSIC, 4'hF, 32'h11223344, 1, 1'b0);
    vecs[1]  = mk("w40_sel5",   1'b1, 32'h40,   CTI_CLASSIC, 4'h5, 32'hAABBCCDD, 1, 1'b0);
    vecs[2]  = mk("r40",        1'b0, 32'h40,   CTI_CLASSIC, 4'hF, 32'h11BB33DD, 1, 1'b0);
    vecs[3]  = mk("w2000_oor",  1'b1, 32'h2000, CTI_CLASSIC, 4'hF, 32'hDEADBEEF, 0, 1'b1);
    vecs[4]  = mk("r2000_oor",  1'b0, 32'h2000, CTI_CLASSIC, 4'hF, 32'h0,        0, 1'b1);
    vecs[5]  = mk("r0_cti_end", 1'b0, 32'h0,    CTI_END,     4'hF, 32'd0,        1, 1'b0);
    vecs[6]  = mk("r4_cti_rsv", 1'b0, 32'h4,    3'b001,      4'hF, 32'd1,        1, 1'b0);
    vecs[7]  = mk("w1ff8",      1'b1, 32'h1FF8, 3'b011,      4'hF, 32'h5A5A0001, 1, 1'b0);
    vecs[8]  = mk("w1ffc",      1'b1, 32'h1FFC, 3'b110,      4'hF, 32'hCAFEF00D, 1, 1'b0);
    vecs[9]  = mk("r1ffc",      1'b0, 32'h1FFC, CTI_CLASSIC, 4'hF, 32'hCAFEF00D, 1, 1'b0);
    vecs[10] = mk("r3f_lowbits",1'b0, 32'h3F,   CTI_CLASSIC, 4'hF, 32'd15,       1, 1'b0);
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].we) wvals[0] = vecs[i].data;
      else if (vecs[i].exp_acks > 0) exp_q.push_back(vecs[i].data);
      run_burst(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].cti, BTE_LINEAR,
                vecs[i].sel, 1, vecs[i].exp_acks, vecs[i].exp_err, -1, 0, -1);
    end

    // Linear read running off the top of the RAM: two acks, then err.
    exp_q = '{32'h5A5A0001, 32'hCAFEF00D};
    run_burst("lin_overflow", 1'b0, 32'h1FF8, CTI_INCR, BTE_LINEAR, 4'hF, 3, 2, 1'b1, -1, 0, -1);

    // Reset during beat 4 of a wrap8 write burst starting at word 10.
    for (int k = 0; k < 16; k++) wvals[k] = 32'hF000_0000 + 32'(k);
    rb_acks = 0;
    hit = 1'b0;
    for (int it = 0; it < 60; it++) begin
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h28; bte = BTE_WRAP8;
      sel = 4'hF; cti = CTI_INCR; dat_i = wvals[rb_acks % 16];
      if (rb_acks == 3) rst_n = 1'b0;
      #1;
      if (ack) rb_acks++;
      if (!rst_n) begin
        hit = 1'b1;
        break;
      end
    end
    check("rstmid_reached", 32'(hit), 32'd1);
    check("rstmid_beat4_presented", 32'(rb_acks), 32'd4);
    @(negedge clk);
    #1;
    check("rstmid_ack", 32'(ack), 32'd0);
    check("rstmid_state", 32'(dut.state_q), 32'(ST_IDLE));
    $display("txn rst_mid_wrap8_wr acks=%0d ack_after=%0d", rb_acks, ack);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q = '{32'hF000_0000, 32'hF000_0001, 32'hF000_0002, 32'd13};
    run_burst("rstmid_readback", 1'b0, 32'h28, CTI_INCR, BTE_LINEAR, 4'hF, 4, 4, 1'b0, -1, 0, -1);
    exp_q = '{32'd9};
    run_burst("rstmid_word9", 1'b0, 32'h24, CTI_CLASSIC, BTE_LINEAR, 4'hF, 1, 1, 1'b0, -1, 0, -1);
    exp_q = '{32'd14};
    run_burst("rstmid_word14", 1'b0, 32'h38, CTI_CLASSIC, BTE_LINEAR, 4'hF, 1, 1, 1'b0, -1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
